// File: rtl/tl_chan_buf.sv
// TileLink five-channel buffer: one independent FIFO (or wire) per channel, plus a drain/idle flag.
// Optional same-cycle bypass into an empty FIFO is enabled with `define TL_CHAN_BUF_BYPASS_EN.
package tl_pkg;
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [3:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } A_chan_bits_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [2:0]  size;
    logic [3:0]  source;
    logic [31:0] address;
    logic [3:0]  mask;
    logic [31:0] data;
    logic        corrupt;
  } B_chan_bits_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [3:0]  source;
    logic [31:0] address;
    logic [31:0] data;
    logic        corrupt;
  } C_chan_bits_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [1:0]  param;
    logic [2:0]  size;
    logic [3:0]  source;
    logic [3:0]  sink;
    logic        denied;
    logic [31:0] data;
    logic        corrupt;
  } D_chan_bits_t;

  typedef struct packed {
    logic [3:0] sink;
  } E_chan_bits_t;
endpackage

module tl_chan_fifo #(
  parameter int  DEPTH = 2,
  parameter type T     = logic
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  input  T     in_bits,
  output logic in_ready,
  output logic out_valid,
  output T     out_bits,
  input  logic out_ready,
  output logic empty
);
  if (DEPTH == 0) begin : g_pass
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign out_valid = in_valid;
    assign out_bits  = in_bits;
    assign in_ready  = out_ready;
    assign empty     = 1'b1;
  end else begin : g_fifo
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count;
    logic          stored, enq, deq;

    assign stored   = (count != '0);
    // Ready is a pure function of state so the upstream timing path stays short.
    assign in_ready = !rst && (count != FULL);
    assign empty    = !stored;

`ifdef TL_CHAN_BUF_BYPASS_EN
    logic byp;
    assign byp       = !rst && !stored && in_valid;
    assign out_valid = (!rst && stored) || byp;
    assign out_bits  = stored ? mem[rd_ptr] : in_bits;
    assign deq       = !rst && stored && out_ready;
    // A bypassed beat taken downstream this cycle is never written.
    assign enq       = in_valid && in_ready && !(byp && out_ready);
`else
    assign out_valid = !rst && stored;
    assign out_bits  = mem[rd_ptr];
    assign deq       = out_valid && out_ready;
    assign enq       = in_valid && in_ready;
`endif

    always_ff @(posedge clk) begin
      if (rst) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (enq) wr_ptr <= (wr_ptr == LAST) ? '0 : wr_ptr + 1'b1;
        if (deq) rd_ptr <= (rd_ptr == LAST) ? '0 : rd_ptr + 1'b1;
        case ({enq, deq})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (enq) mem[wr_ptr] <= in_bits;
    end
  end
endmodule

module tl_chan_buf #(
  parameter int A_DEPTH = 2,
  parameter int B_DEPTH = 2,
  parameter int C_DEPTH = 2,
  parameter int D_DEPTH = 2,
  parameter int E_DEPTH = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 up_a_valid,
  input  tl_pkg::A_chan_bits_t up_a_bits,
  output logic                 up_a_ready,
  output logic                 dn_a_valid,
  output tl_pkg::A_chan_bits_t dn_a_bits,
  input  logic                 dn_a_ready,
  input  logic                 dn_b_valid,
  input  tl_pkg::B_chan_bits_t dn_b_bits,
  output logic                 dn_b_ready,
  output logic                 up_b_valid,
  output tl_pkg::B_chan_bits_t up_b_bits,
  input  logic                 up_b_ready,
  input  logic                 up_c_valid,
  input  tl_pkg::C_chan_bits_t up_c_bits,
  output logic                 up_c_ready,
  output logic                 dn_c_valid,
  output tl_pkg::C_chan_bits_t dn_c_bits,
  input  logic                 dn_c_ready,
  input  logic                 dn_d_valid,
  input  tl_pkg::D_chan_bits_t dn_d_bits,
  output logic                 dn_d_ready,
  output logic                 up_d_valid,
  output tl_pkg::D_chan_bits_t up_d_bits,
  input  logic                 up_d_ready,
  input  logic                 up_e_valid,
  input  tl_pkg::E_chan_bits_t up_e_bits,
  output logic                 up_e_ready,
  output logic                 dn_e_valid,
  output tl_pkg::E_chan_bits_t dn_e_bits,
  input  logic                 dn_e_ready,
  output logic                 idle_o
);
  logic [4:0] empty;

  tl_chan_fifo #(.DEPTH(A_DEPTH), .T(tl_pkg::A_chan_bits_t)) u_a (
    .clk(clk_i), .rst(rst_i),
    .in_valid(up_a_valid), .in_bits(up_a_bits), .in_ready(up_a_ready),
    .out_valid(dn_a_valid), .out_bits(dn_a_bits), .out_ready(dn_a_ready),
    .empty(empty[0]));

  tl_chan_fifo #(.DEPTH(B_DEPTH), .T(tl_pkg::B_chan_bits_t)) u_b (
    .clk(clk_i), .rst(rst_i),
    .in_valid(dn_b_valid), .in_bits(dn_b_bits), .in_ready(dn_b_ready),
    .out_valid(up_b_valid), .out_bits(up_b_bits), .out_ready(up_b_ready),
    .empty(empty[1]));

  tl_chan_fifo #(.DEPTH(C_DEPTH), .T(tl_pkg::C_chan_bits_t)) u_c (
    .clk(clk_i), .rst(rst_i),
    .in_valid(up_c_valid), .in_bits(up_c_bits), .in_ready(up_c_ready),
    .out_valid(dn_c_valid), .out_bits(dn_c_bits), .out_ready(dn_c_ready),
    .empty(empty[2]));

  tl_chan_fifo #(.DEPTH(D_DEPTH), .T(tl_pkg::D_chan_bits_t)) u_d (
    .clk(clk_i), .rst(rst_i),
    .in_valid(dn_d_valid), .in_bits(dn_d_bits), .in_ready(dn_d_ready),
    .out_valid(up_d_valid), .out_bits(up_d_bits), .out_ready(up_d_ready),
    .empty(empty[3]));

  tl_chan_fifo #(.DEPTH(E_DEPTH), .T(tl_pkg::E_chan_bits_t)) u_e (
    .clk(clk_i), .rst(rst_i),
    .in_valid(up_e_valid), .in_bits(up_e_bits), .in_ready(up_e_ready),
    .out_valid(dn_e_valid), .out_bits(dn_e_bits), .out_ready(dn_e_ready),
    .empty(empty[4]));

  // Pass-through channels report empty=1, so they drop out of the AND.
  assign idle_o = &empty;
endmodule

// File: tb/tb_tl_chan_buf.sv
// Bench for tl_chan_buf: directed scenarios plus a randomized queue-model run on A and D.
// B is built as a wire (depth 0); the rest use default depths.
module tb_tl_chan_buf;
  import tl_pkg::*;

`ifdef TL_CHAN_BUF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam int LAT = BYP ? 0 : 1;

  logic clk_i = 1'b0;
  logic rst_i;
  logic up_a_valid, up_a_ready, dn_a_valid, dn_a_ready;
  logic dn_b_valid, dn_b_ready, up_b_valid, up_b_ready;
  logic up_c_valid, up_c_ready, dn_c_valid, dn_c_ready;
  logic dn_d_valid, dn_d_ready, up_d_valid, up_d_ready;
  logic up_e_valid, up_e_ready, dn_e_valid, dn_e_ready;
  logic idle_o;
  A_chan_bits_t up_a_bits, dn_a_bits;
  B_chan_bits_t dn_b_bits, up_b_bits;
  C_chan_bits_t up_c_bits, dn_c_bits;
  D_chan_bits_t dn_d_bits, up_d_bits;
  E_chan_bits_t up_e_bits, dn_e_bits;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  tl_chan_buf #(.A_DEPTH(2), .B_DEPTH(0), .C_DEPTH(2), .D_DEPTH(2), .E_DEPTH(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .up_a_valid(up_a_valid), .up_a_bits(up_a_bits), .up_a_ready(up_a_ready),
    .dn_a_valid(dn_a_valid), .dn_a_bits(dn_a_bits), .dn_a_ready(dn_a_ready),
    .dn_b_valid(dn_b_valid), .dn_b_bits(dn_b_bits), .dn_b_ready(dn_b_ready),
    .up_b_valid(up_b_valid), .up_b_bits(up_b_bits), .up_b_ready(up_b_ready),
    .up_c_valid(up_c_valid), .up_c_bits(up_c_bits), .up_c_ready(up_c_ready),
    .dn_c_valid(dn_c_valid), .dn_c_bits(dn_c_bits), .dn_c_ready(dn_c_ready),
    .dn_d_valid(dn_d_valid), .dn_d_bits(dn_d_bits), .dn_d_ready(dn_d_ready),
    .up_d_valid(up_d_valid), .up_d_bits(up_d_bits), .up_d_ready(up_d_ready),
    .up_e_valid(up_e_valid), .up_e_bits(up_e_bits), .up_e_ready(up_e_ready),
    .dn_e_valid(dn_e_valid), .dn_e_bits(dn_e_bits), .dn_e_ready(dn_e_ready),
    .idle_o(idle_o));

  function automatic A_chan_bits_t rnd_a();
    A_chan_bits_t x;
    x.opcode = 3'($urandom); x.param = 3'($urandom); x.size = 3'($urandom);
    x.source = 4'($urandom); x.address = $urandom; x.mask = 4'($urandom);
    x.data = $urandom; x.corrupt = 1'($urandom);
    return x;
  endfunction

  function automatic B_chan_bits_t rnd_b();
    B_chan_bits_t x;
    x.opcode = 3'($urandom); x.param = 2'($urandom); x.size = 3'($urandom);
    x.source = 4'($urandom); x.address = $urandom; x.mask = 4'($urandom);
    x.data = $urandom; x.corrupt = 1'($urandom);
    return x;
  endfunction

  function automatic C_chan_bits_t rnd_c();
    C_chan_bits_t x;
    x.opcode = 3'($urandom); x.param = 3'($urandom); x.size = 3'($urandom);
    x.source = 4'($urandom); x.address = $urandom; x.data = $urandom;
    x.corrupt = 1'($urandom);
    return x;
  endfunction

  function automatic D_chan_bits_t rnd_d();
    D_chan_bits_t x;
    x.opcode = 3'($urandom); x.param = 2'($urandom); x.size = 3'($urandom);
    x.source = 4'($urandom); x.sink = 4'($urandom); x.denied = 1'($urandom);
    x.data = $urandom; x.corrupt = 1'($urandom);
    return x;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    up_a_valid = 0; dn_b_valid = 0; up_c_valid = 0; dn_d_valid = 0; up_e_valid = 0;
    dn_a_ready = 0; up_b_ready = 0; dn_c_ready = 0; up_d_ready = 0; dn_e_ready = 0;
    up_a_bits = '0; dn_b_bits = '0; up_c_bits = '0; dn_d_bits = '0; up_e_bits = '0;
    tick(); tick();
    settle();
    n_tests++; if (up_a_ready !== 1'b0) begin n_fail++; $display("FAIL rst_hold_a_ready got %b exp 0", up_a_ready); end
    n_tests++; if (dn_a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_hold_a_valid got %b exp 0", dn_a_valid); end
    n_tests++; if (up_e_ready !== 1'b0) begin n_fail++; $display("FAIL rst_hold_e_ready got %b exp 0", up_e_ready); end
    rst_i = 1'b0;
    settle();
    n_tests++; if (up_a_ready !== 1'b1) begin n_fail++; $display("FAIL rst_a_ready got %b exp 1", up_a_ready); end
    n_tests++; if (dn_a_valid !== 1'b0) begin n_fail++; $display("FAIL rst_a_valid got %b exp 0", dn_a_valid); end
    n_tests++; if (up_c_ready !== 1'b1) begin n_fail++; $display("FAIL rst_c_ready got %b exp 1", up_c_ready); end
    n_tests++; if (dn_d_ready !== 1'b1) begin n_fail++; $display("FAIL rst_d_ready got %b exp 1", dn_d_ready); end
    n_tests++; if (up_d_valid !== 1'b0) begin n_fail++; $display("FAIL rst_d_valid got %b exp 0", up_d_valid); end
    n_tests++; if (up_e_ready !== 1'b1) begin n_fail++; $display("FAIL rst_e_ready got %b exp 1", up_e_ready); end
    n_tests++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL rst_idle got %b exp 1", idle_o); end
    tick();
  endtask

  task automatic test_a_stream();
    A_chan_bits_t beats[8];
    for (int i = 0; i < 8; i++) begin
      beats[i] = rnd_a();
      beats[i].address = 32'h1000 + 32'(8 * i);
    end
    dn_a_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      int j;
      up_a_valid = (i < 8);
      if (i < 8) up_a_bits = beats[i];
      settle();
      if (i < 8) begin
        n_tests++; if (up_a_ready !== 1'b1) begin n_fail++; $display("FAIL a_stream_ready cyc %0d got %b exp 1", i, up_a_ready); end
      end
      j = i - LAT;
      n_tests++;
      if (dn_a_valid !== (j >= 0 && j < 8)) begin
        n_fail++; $display("FAIL a_stream_valid cyc %0d got %b exp %b", i, dn_a_valid, (j >= 0 && j < 8));
      end else if (j >= 0 && j < 8) begin
        n_tests++; if (dn_a_bits !== beats[j]) begin n_fail++; $display("FAIL a_stream_bits beat %0d got %h exp %h", j, dn_a_bits, beats[j]); end
      end
      tick();
    end
    up_a_valid = 1'b0;
    dn_a_ready = 1'b0;
  endtask

  task automatic test_d_backpressure();
    D_chan_bits_t beats[3];
    D_chan_bits_t got[$];
    int k = 0;
    for (int i = 0; i < 3; i++) beats[i] = rnd_d();
    for (int cyc = 0; cyc < 20; cyc++) begin
      up_d_ready = (cyc >= 4);
      dn_d_valid = (k < 3);
      if (k < 3) dn_d_bits = beats[k];
      settle();
      if (cyc < 2) begin
        n_tests++; if (dn_d_ready !== 1'b1) begin n_fail++; $display("FAIL d_accept cyc %0d got %b exp 1", cyc, dn_d_ready); end
      end else if (cyc <= 4) begin
        n_tests++; if (dn_d_ready !== 1'b0) begin n_fail++; $display("FAIL d_stall cyc %0d got %b exp 0", cyc, dn_d_ready); end
      end
      if (up_d_valid && up_d_ready) got.push_back(up_d_bits);
      if (dn_d_valid && dn_d_ready) k++;
      tick();
      if (k == 3 && got.size() >= 3) break;
    end
    dn_d_valid = 1'b0;
    settle();
    n_tests++; if (got.size() != 3) begin n_fail++; $display("FAIL d_count got %0d exp 3", got.size()); end
    for (int i = 0; i < 3 && i < got.size(); i++) begin
      n_tests++; if (got[i] !== beats[i]) begin n_fail++; $display("FAIL d_order beat %0d got %h exp %h", i, got[i], beats[i]); end
    end
    n_tests++; if (up_d_valid !== 1'b0) begin n_fail++; $display("FAIL d_dup got %b exp 0", up_d_valid); end
    up_d_ready = 1'b0;
  endtask

  task automatic test_e_rate();
    E_chan_bits_t beats[4];
    int k = 0, outs = 0;
    for (int i = 0; i < 4; i++) beats[i] = E_chan_bits_t'(4'(i + 5));
    dn_e_ready = 1'b1;
    for (int cyc = 0; cyc < 30; cyc++) begin
      up_e_valid = (k < 4);
      if (k < 4) up_e_bits = beats[k];
      settle();
      if (dn_e_valid) begin
        int exp_cyc;
        exp_cyc = BYP ? outs : 2 * outs + 1;
        n_tests++; if (cyc != exp_cyc) begin n_fail++; $display("FAIL e_rate beat %0d cycle got %0d exp %0d", outs, cyc, exp_cyc); end
        if (outs < 4) begin
          n_tests++; if (dn_e_bits !== beats[outs]) begin n_fail++; $display("FAIL e_bits beat %0d got %h exp %h", outs, dn_e_bits, beats[outs]); end
        end
        outs++;
      end
      if (up_e_valid && up_e_ready) k++;
      tick();
      if (outs >= 4) break;
    end
    up_e_valid = 1'b0;
    n_tests++; if (outs != 4) begin n_fail++; $display("FAIL e_count got %0d exp 4", outs); end
    dn_e_ready = 1'b0;
  endtask

  task automatic test_reset_mid();
    A_chan_bits_t old0, old1;
    old0 = rnd_a(); old1 = rnd_a();
    dn_a_ready = 1'b0;
    up_a_valid = 1'b1; up_a_bits = old0; tick();
    up_a_bits = old1; tick();
    up_a_valid = 1'b0;
    settle();
    n_tests++; if (up_a_ready !== 1'b0) begin n_fail++; $display("FAIL mid_full_ready got %b exp 0", up_a_ready); end
    n_tests++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL mid_busy_idle got %b exp 0", idle_o); end
    n_tests++; if (dn_a_bits !== old0) begin n_fail++; $display("FAIL mid_head got %h exp %h", dn_a_bits, old0); end
    rst_i = 1'b1;
    settle();
    n_tests++; if (dn_a_valid !== 1'b0) begin n_fail++; $display("FAIL mid_rst_valid got %b exp 0", dn_a_valid); end
    tick();
    rst_i = 1'b0;
    dn_a_ready = 1'b1;
    settle();
    n_tests++; if (dn_a_valid !== 1'b0) begin n_fail++; $display("FAIL mid_after_valid got %b exp 0", dn_a_valid); end
    n_tests++; if (up_a_ready !== 1'b1) begin n_fail++; $display("FAIL mid_after_ready got %b exp 1", up_a_ready); end
    n_tests++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL mid_after_idle got %b exp 1", idle_o); end
    for (int i = 0; i < 3; i++) begin
      tick(); settle();
      n_tests++; if (dn_a_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ghost cyc %0d got %b exp 0", i, dn_a_valid); end
    end
    dn_a_ready = 1'b0;
  endtask

  task automatic test_b_passthru();
    for (int i = 0; i < 24; i++) begin
      dn_b_valid = 1'($urandom);
      dn_b_bits  = rnd_b();
      up_b_ready = 1'($urandom);
      settle();
      n_tests++; if (up_b_valid !== dn_b_valid) begin n_fail++; $display("FAIL b_valid cyc %0d got %b exp %b", i, up_b_valid, dn_b_valid); end
      n_tests++; if (up_b_bits !== dn_b_bits) begin n_fail++; $display("FAIL b_bits cyc %0d got %h exp %h", i, up_b_bits, dn_b_bits); end
      n_tests++; if (dn_b_ready !== up_b_ready) begin n_fail++; $display("FAIL b_ready cyc %0d got %b exp %b", i, dn_b_ready, up_b_ready); end
      n_tests++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL b_idle cyc %0d got %b exp 1", i, idle_o); end
      tick();
    end
    dn_b_valid = 1'b0;
    up_b_ready = 1'b0;
  endtask

  task automatic test_c_bypass();
    C_chan_bits_t b0, b1;
    b0 = rnd_c(); b1 = rnd_c();
    // Ready downstream: bypass consumes in-cycle, otherwise one cycle later.
    up_c_valid = 1'b1; up_c_bits = b0; dn_c_ready = 1'b1;
    settle();
    n_tests++; if (dn_c_valid !== BYP) begin n_fail++; $display("FAIL c_same_cycle got %b exp %b", dn_c_valid, BYP); end
    if (BYP) begin
      n_tests++; if (dn_c_bits !== b0) begin n_fail++; $display("FAIL c_byp_bits got %h exp %h", dn_c_bits, b0); end
    end
    n_tests++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL c_idle0 got %b exp 1", idle_o); end
    tick();
    up_c_valid = 1'b0;
    settle();
    n_tests++; if (dn_c_valid !== !BYP) begin n_fail++; $display("FAIL c_next_valid got %b exp %b", dn_c_valid, !BYP); end
    if (!BYP) begin
      n_tests++; if (dn_c_bits !== b0) begin n_fail++; $display("FAIL c_next_bits got %h exp %h", dn_c_bits, b0); end
    end
    n_tests++; if (idle_o !== BYP) begin n_fail++; $display("FAIL c_idle1 got %b exp %b", idle_o, BYP); end
    tick();
    // Not ready downstream: the beat must be stored and held.
    up_c_valid = 1'b1; up_c_bits = b1; dn_c_ready = 1'b0;
    tick();
    up_c_valid = 1'b0;
    settle();
    n_tests++; if (dn_c_valid !== 1'b1) begin n_fail++; $display("FAIL c_held_valid got %b exp 1", dn_c_valid); end
    n_tests++; if (dn_c_bits !== b1) begin n_fail++; $display("FAIL c_held_bits got %h exp %h", dn_c_bits, b1); end
    n_tests++; if (idle_o !== 1'b0) begin n_fail++; $display("FAIL c_held_idle got %b exp 0", idle_o); end
    dn_c_ready = 1'b1;
    tick();
    settle();
    n_tests++; if (dn_c_valid !== 1'b0) begin n_fail++; $display("FAIL c_drained got %b exp 0", dn_c_valid); end
    dn_c_ready = 1'b0;
  endtask

  task automatic test_random();
    A_chan_bits_t qa[$];
    D_chan_bits_t qd[$];
    for (int cyc = 0; cyc < 410; cyc++) begin
      bit ea_rdy, ea_vld, ed_rdy, ed_vld, e_idle, a_enq, a_deq, d_enq, d_deq;
      int sa, sd;
      bit drain;
      drain = (cyc >= 400);
      up_a_valid = drain ? 1'b0 : ($urandom_range(0, 9) < 6);
      up_a_bits  = rnd_a();
      dn_a_ready = drain ? 1'b1 : ($urandom_range(0, 9) < 6);
      dn_d_valid = drain ? 1'b0 : ($urandom_range(0, 9) < 6);
      dn_d_bits  = rnd_d();
      up_d_ready = drain ? 1'b1 : ($urandom_range(0, 9) < 6);
      settle();
      sa = qa.size(); sd = qd.size();
      ea_rdy = (sa < 2);
      ea_vld = (sa > 0) || (BYP && up_a_valid);
      ed_rdy = (sd < 2);
      ed_vld = (sd > 0) || (BYP && dn_d_valid);
      e_idle = (sa == 0) && (sd == 0);
      n_tests++; if (up_a_ready !== ea_rdy) begin n_fail++; $display("FAIL rnd_a_ready cyc %0d got %b exp %b", cyc, up_a_ready, ea_rdy); end
      n_tests++; if (dn_a_valid !== ea_vld) begin n_fail++; $display("FAIL rnd_a_valid cyc %0d got %b exp %b", cyc, dn_a_valid, ea_vld); end
      if (ea_vld) begin
        n_tests++;
        if (dn_a_bits !== ((sa > 0) ? qa[0] : up_a_bits)) begin
          n_fail++; $display("FAIL rnd_a_bits cyc %0d got %h exp %h", cyc, dn_a_bits, (sa > 0) ? qa[0] : up_a_bits);
        end
      end
      n_tests++; if (dn_d_ready !== ed_rdy) begin n_fail++; $display("FAIL rnd_d_ready cyc %0d got %b exp %b", cyc, dn_d_ready, ed_rdy); end
      n_tests++; if (up_d_valid !== ed_vld) begin n_fail++; $display("FAIL rnd_d_valid cyc %0d got %b exp %b", cyc, up_d_valid, ed_vld); end
      if (ed_vld) begin
        n_tests++;
        if (up_d_bits !== ((sd > 0) ? qd[0] : dn_d_bits)) begin
          n_fail++; $display("FAIL rnd_d_bits cyc %0d got %h exp %h", cyc, up_d_bits, (sd > 0) ? qd[0] : dn_d_bits);
        end
      end
      n_tests++; if (idle_o !== e_idle) begin n_fail++; $display("FAIL rnd_idle cyc %0d got %b exp %b", cyc, idle_o, e_idle); end
      a_enq = up_a_valid && ea_rdy; a_deq = ea_vld && dn_a_ready;
      d_enq = dn_d_valid && ed_rdy; d_deq = ed_vld && up_d_ready;
      if (a_deq && sa > 0) void'(qa.pop_front());
      if (a_enq && !(sa == 0 && a_deq)) qa.push_back(up_a_bits);
      if (d_deq && sd > 0) void'(qd.pop_front());
      if (d_enq && !(sd == 0 && d_deq)) qd.push_back(dn_d_bits);
      tick();
    end
    n_tests++; if (idle_o !== 1'b1) begin n_fail++; $display("FAIL rnd_final_idle got %b exp 1", idle_o); end
    dn_a_ready = 1'b0;
    up_d_ready = 1'b0;
  endtask

  initial begin
    test_reset();
    test_a_stream();
    test_d_backpressure();
    test_e_rate();
    test_reset_mid();
    test_b_passthru();
    test_c_bypass();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/tl_chan_buf.md
Name: tl_chan_buf

Overview:
- Parametrised TileLink channel buffer for all five channels (A/C/E downstream, B/D upstream). Each channel has its own depth.
- Inserted between a TL master agent (core/L1) and a TL slave agent (L2/interconnect) to break timing paths and absorb backpressure.
- Exposes an idle indication so upstream fence/flush logic can wait for all in-flight beats to drain.

Parameters:
- A_DEPTH, 2, A-channel FIFO entries; 0 = wire pass-through.
- B_DEPTH, 2, B-channel FIFO entries; 0 = wire pass-through.
- C_DEPTH, 2, C-channel FIFO entries; 0 = wire pass-through.
- D_DEPTH, 2, D-channel FIFO entries; 0 = wire pass-through.
- E_DEPTH, 1, E-channel FIFO entries; 0 = wire pass-through.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous active-high reset
- up_a_valid/up_a_bits/up_a_ready  in/in/out  1/A_chan_bits_t/1  A from master side
- dn_a_valid/dn_a_bits/dn_a_ready  out/out/in  1/A_chan_bits_t/1  A to slave side
- dn_b_valid/dn_b_bits/dn_b_ready  in/in/out  1/B_chan_bits_t/1  B from slave side
- up_b_valid/up_b_bits/up_b_ready  out/out/in  1/B_chan_bits_t/1  B to master side
- up_c_*, dn_c_*  as A, type C_chan_bits_t
- dn_d_*, up_d_*  as B, type D_chan_bits_t
- up_e_*, dn_e_*  as A, type E_chan_bits_t
- idle_o  out  1  all non-zero-depth FIFOs empty
- Channel bit types come from tl_pkg.

Behaviour:
Interface and per-channel structure
- One clock clk_i; reset rst_i is synchronous and active-high.
- Each channel is an independent FIFO instance. There is no ordering between channels.

Pass-through (DEPTH == 0)
- out_valid = in_valid, out_bits = in_bits, in_ready = out_ready. Purely combinational, no state.

FIFO (DEPTH ≥ 1)
- Circular buffer with wr_ptr and rd_ptr, each clog2(DEPTH) bits (1 bit minimum), plus count of clog2(DEPTH+1) bits.
- Pointers wrap from DEPTH-1 to 0. DEPTH need not be a power of two.
- in_ready = (count != DEPTH). It depends only on state, never combinationally on out_ready.
- out_valid = (count != 0); out_bits = mem[rd_ptr]. Output is registered data.
- Enqueue when in_valid & in_ready: write mem[wr_ptr], increment wr_ptr.
- Dequeue when out_valid & out_ready: increment rd_ptr.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance.
- Allowed when full, if and only if a dequeue also happens? No. When full, in_ready = 0, so no enqueue that cycle even if out_ready = 1. A full FIFO accepts again the cycle after a dequeue.
- Latency: minimum 1 cycle, in to out.
- Throughput: DEPTH ≥ 2 sustains 1 beat/cycle. DEPTH == 1 sustains 1 beat per 2 cycles.
- Output stability: once out_valid is high, out_bits holds stable until handshake. No entry is ever overwritten before it is dequeued.

Reset
- Applies in any state, including mid-burst.
- Clears count and pointers, so every out_valid = 0 and every in_ready = 1 (for DEPTH ≥ 1) in the cycle after rst_i is sampled high.
- Stored beats are discarded. Data memory is not reset.
- While rst_i = 1: in_ready = 0 and out_valid = 0 for all FIFO channels. Pass-through channels are unaffected.

idle_o
- AND over all channels with DEPTH ≥ 1 of (count == 0). Constant 1 if all depths are 0.
- Reset value 1.

Optional Feature:
- Macro: TL_CHAN_BUF_BYPASS_EN.
- Defined: when a FIFO is empty and in_valid = 1, the beat is presented combinationally on out_valid/out_bits in the same cycle.
- If out_ready = 1 that cycle, the beat is consumed without being written (0-cycle latency, count stays 0). Otherwise it is written normally.
- in_ready is unchanged from normal operation.
- idle_o still reflects stored beats only.
- Undefined: strict registered behaviour as above, minimum latency 1 cycle.

Test Plan:
1. A_DEPTH=2: drive 8 back-to-back A beats (address 0x1000..0x1038) with dn_a_ready=1 -> dn_a emits the same 8 beats in order, first at cycle+1, one per cycle, up_a_ready stays 1.
2. D_DEPTH=2: hold up_d_ready=0 and push 3 D beats -> third beat stalls with dn_d_ready=0 after 2 accepts; raise up_d_ready -> beats 1,2,3 delivered in order, no loss or duplicate.
3. E_DEPTH=1: stream 4 E beats with ready always high -> exactly 1 beat per 2 cycles, 8 cycles total.
4. Reset mid-operation: fill A with 2 beats, assert rst_i for 1 cycle -> next cycle dn_a_valid=0, up_a_ready=1, idle_o=1; old beats never appear.
5. B_DEPTH=0: toggle dn_b_valid and up_b_ready randomly -> up_b mirrors dn_b combinationally every cycle; idle_o unaffected.
6. With TL_CHAN_BUF_BYPASS_EN, C_DEPTH=2: single C beat into empty FIFO with dn_c_ready=1 -> dn_c_valid in same cycle, count stays 0, idle_o stays 1.
